// File: rtl/ex1_b_demux.sv
// Registered 1-to-5 demultiplexer: routes M into one of five per-channel FIFOs (U..Y) by {s2,s1,s0}.
// Optional accepted-word counter on acc_cnt, built only when EX1_B_DEMUX_CNT_EN is defined.
module ex1_b_demux #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s2,
  input  logic                  s1,
  input  logic                  s0,
  input  logic [DATA_WIDTH-1:0] M,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] U,
  output logic [DATA_WIDTH-1:0] V,
  output logic [DATA_WIDTH-1:0] W,
  output logic [DATA_WIDTH-1:0] X,
  output logic [DATA_WIDTH-1:0] Y,
  output logic [4:0]            out_valid,
  input  logic [4:0]            out_ready,
  output logic [7:0]            acc_cnt
);

  localparam int NCH = 5;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t           mem    [NCH][DEPTH];
  logic [PW-1:0]   wr_ptr [NCH];
  logic [PW-1:0]   rd_ptr [NCH];
  logic [CW-1:0]   count  [NCH];

  logic [2:0]      dest;
  logic            push;
  logic [NCH-1:0]  full;
  logic [NCH-1:0]  push_ch;
  logic [NCH-1:0]  pop_ch;

  // Codes 100..111 all alias onto channel Y.
  always_comb begin
    dest = 3'd4;
    case ({s2, s1, s0})
      3'b000:  dest = 3'd0;
      3'b001:  dest = 3'd1;
      3'b010:  dest = 3'd2;
      3'b011:  dest = 3'd3;
      default: dest = 3'd4;
    endcase
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    full      = '0;
    out_valid = '0;
    pop_ch    = '0;
    push_ch   = '0;
    for (int i = 0; i < NCH; i++) begin
      full[i]      = (count[i] == CW'(DEPTH));
      out_valid[i] = (count[i] != '0);
      pop_ch[i]    = out_valid[i] && out_ready[i];
    end
    // in_ready looks only at registered fullness, so a same-cycle pop never passes a word through.
    in_ready = !full[dest];
    push     = in_valid && in_ready;
    for (int i = 0; i < NCH; i++) begin
      push_ch[i] = push && (dest == 3'(i));
    end
  end

  // NOTE: storage is reset too, because the channel outputs must read zero as soon as rst_n falls.
  // NOTE: all state updates use non-blocking assignments so every channel samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push_ch[i]) begin
          mem[i][wr_ptr[i]] <= M;
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (pop_ch[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        case ({push_ch[i], pop_ch[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign U = mem[0][rd_ptr[0]];
  assign V = mem[1][rd_ptr[1]];
  assign W = mem[2][rd_ptr[2]];
  assign X = mem[3][rd_ptr[3]];
  assign Y = mem[4][rd_ptr[4]];

`ifdef EX1_B_DEMUX_CNT_EN
  logic [7:0] acc_q;

  // Saturating count of accepted pushes; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 8'h00;
    end else if (push && (acc_q != 8'hFF)) begin
      acc_q <= acc_q + 8'd1;
    end
  end

  assign acc_cnt = acc_q;
`else
  assign acc_cnt = 8'h00;
`endif

endmodule
